// File: rtl/branch_resolve_bht_pkg.sv
// Shared opcode/rt constants and 2-bit predictor counter encodings
// for the decode-stage branch resolver.
package branch_resolve_bht_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] c,
                                            input logic tk);
        logic [1:0] n;
        n = c;
        if (tk && c != CTR_ST)
            n = c + 2'd1;
        else if (!tk && c != CTR_SNT)
            n = c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch decode and condition evaluation for
// BEQ/BNE/BLEZ/BGTZ and the REGIMM compare-with-zero group.
module branch_cond_eval
    import branch_resolve_bht_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op_i,
    input  logic [4:0]        rt_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              is_branch_o,
    output logic              taken_o
);

    logic sign;
    logic zero;
    logic eq;
    logic rimm;

    assign sign = a_i[DATA_W-1];
    assign zero = (a_i == '0);
    assign eq   = (a_i == b_i);
    assign rimm = (op_i == OP_REGIMM);

    always_comb begin
        is_branch_o = 1'b0;
        taken_o     = 1'b0;
        unique case (1'b1)
            op_i == OP_BEQ: begin
                is_branch_o = 1'b1;
                taken_o     = eq;
            end
            op_i == OP_BNE: begin
                is_branch_o = 1'b1;
                taken_o     = ~eq;
            end
            op_i == OP_BLEZ: begin
                is_branch_o = 1'b1;
                taken_o     = sign | zero;
            end
            op_i == OP_BGTZ: begin
                is_branch_o = 1'b1;
                taken_o     = ~sign & ~zero;
            end
            rimm && (rt_i == RT_BLTZ || rt_i == RT_BLTZAL): begin
                is_branch_o = 1'b1;
                taken_o     = sign;
            end
            rimm && (rt_i == RT_BGEZ || rt_i == RT_BGEZAL): begin
                is_branch_o = 1'b1;
                taken_o     = ~sign;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Decode-stage branch resolver: E-stage outcome registers, 2-bit BHT
// serving fetch predictions, and saturating branch/mispredict counters.
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   f_pc_i,
    output logic              f_pred_taken_o,
    input  logic              d_valid_i,
    input  logic [5:0]        d_op_i,
    input  logic [4:0]        d_rt_i,
    input  logic [DATA_W-1:0] d_a_i,
    input  logic [DATA_W-1:0] d_b_i,
    input  logic [PC_W-1:0]   d_pc_i,
    input  logic              d_pred_taken_i,
    output logic              e_valid_o,
    output logic              e_taken_o,
    output logic              e_mispredict_o,
    output logic [CNT_W-1:0]  br_cnt_o,
    output logic [CNT_W-1:0]  mis_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       bht_q [ENTRIES];
    logic [1:0]       ctr_d;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic             is_branch;
    logic             taken;
    logic             cap;
    logic             mis;
    logic             e_valid_q, e_taken_q, e_mis_q;
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;
    logic             unused_pc;

    branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
        .op_i        (d_op_i),
        .rt_i        (d_rt_i),
        .a_i         (d_a_i),
        .b_i         (d_b_i),
        .is_branch_o (is_branch),
        .taken_o     (taken)
    );

    assign f_idx = f_pc_i[IDX_W+1:2];
    assign d_idx = d_pc_i[IDX_W+1:2];
    assign unused_pc = ^{f_pc_i, d_pc_i};

    assign cap   = d_valid_i & is_branch & ~stall_i & ~flush_i;
    assign mis   = taken ^ d_pred_taken_i;
    assign ctr_d = ctr_next(bht_q[d_idx], taken);

    // Fetch read sees the pre-edge entry; no write bypass.
    assign f_pred_taken_o = bht_q[f_idx][1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++)
                bht_q[i] <= CTR_WNT;
        end else if (cap) begin
            bht_q[d_idx] <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_valid_q <= 1'b0;
            e_taken_q <= 1'b0;
            e_mis_q   <= 1'b0;
        end else if (flush_i) begin
            e_valid_q <= 1'b0;
        end else if (!stall_i) begin
            e_valid_q <= cap;
            if (cap) begin
                e_taken_q <= taken;
                e_mis_q   <= mis;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (cap) begin
            if (br_cnt_q != '1)
                br_cnt_q <= br_cnt_q + 1'b1;
            if (mis && mis_cnt_q != '1)
                mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign e_valid_o      = e_valid_q;
    assign e_taken_o      = e_taken_q;
    assign e_mispredict_o = e_mis_q;
    assign br_cnt_o       = br_cnt_q;
    assign mis_cnt_o      = mis_cnt_q;

endmodule
